wb_commit_stage: RTL
====================

Name: wb_commit_stage

Overview:
- Parametrised write-back/commit stage for the multi-issue MIPS pipeline; sits between MEM and the register file / CP0.
- Latches a bundle of LANES instructions from MEM and retires it in program order through RF_WPORTS register-file write ports.
- May take several cycles per bundle; supports at most one CP0-touching lane per cycle.
- Raises precise exception/ERET flushes and squashes younger lanes of the same bundle.

Parameters:
- LANES, 2, instructions per MEM->WB bundle (1..4).
- RF_WPORTS, 1, register-file write ports = max lanes retired per cycle (1..LANES).
- DATA_W, 32, datapath width.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- ws_allowin  out  1  WB can accept a bundle this cycle.
- ms_to_ws_valid  in  1  MEM offers a bundle.
- ms_to_ws_lane_mask  in  LANES  per-lane occupancy; bit i = lane i holds an instruction.
- ms_to_ws_bus  in  LANES*`WS_LANE_WD  packed lanes; lane 0 is oldest.
- ws_cp0_raddr  out  5  CP0 read address (mfc0).
- cp0_rdata  in  DATA_W  CP0 read data, combinational, same cycle.
- wb_to_cp0_register_bus  out  `WB_TO_CP0_REGISTER_BUS_WD  {ex, excode[4:0], badvaddr, bd, pc, mtc0_we, cp0_addr, rt_value, eret}.
- ws_flush  out  1  exception or ERET retiring this cycle.
- ws_eret  out  1  ERET retiring this cycle.
- rf_we  out  RF_WPORTS  per-port write enable.
- rf_waddr  out  RF_WPORTS*5  per-port write address.
- rf_wdata  out  RF_WPORTS*DATA_W  per-port write data.
- debug_wb_pc  out  RF_WPORTS*32  trace PC, per port.
- debug_wb_rf_wen  out  RF_WPORTS*4  trace write enable, {4{rf_we[p]}}.
- debug_wb_rf_wnum  out  RF_WPORTS*5  trace register number.
- debug_wb_rf_wdata  out  RF_WPORTS*DATA_W  trace write data.

Behaviour:
- Lane fields, high to low: rt_value, eret, bd, mtc0, cp0_addr[4:0], res_from_cp0, badvaddr, ex, excode[4:0], gr_we, dest[4:0], result, pc; total 149 bits.
- CP0 lane: any lane with ex | eret | mtc0 | res_from_cp0.
- State: ws_valid; bundle register; mask register; cur, a pointer of clog2(LANES)+1 bits to the oldest unretired lane.
- Reset (resetn==0 at posedge): ws_valid=0, cur=0, mask=0.
  - All outputs 0 while ws_valid=0, except ws_allowin=1.
  - Reset mid-bundle discards the remaining lanes.
- Accept: when ms_to_ws_valid && ws_allowin && !ws_flush, latch bus and mask; set cur=0 and ws_valid=1.
  - A bundle with mask==0 is accepted and leaves in the next cycle without side effects.
- Commit group (combinational, each valid cycle):
  - Takes up to RF_WPORTS occupied lanes at or after cur, in lane order; unoccupied lanes cost no port.
  - The group ends at and includes the first CP0 lane.
  - Port p carries the p-th lane of the group.
- Per lane in group:
  - rf_we = gr_we && !ex.
  - rf_wdata = res_from_cp0 ? cp0_rdata : result.
  - dest 0 is passed through unchanged; the register file ignores r0.
- CP0 lane outputs:
  - Drives wb_to_cp0_register_bus from that lane.
  - mtc0_we = mtc0 && ws_valid.
  - ws_cp0_raddr = cp0_addr.
  - With no CP0 lane in the group, the bus is all-zero.
- ex lane: no RF write; ws_flush=1; all younger lanes squashed; ws_valid=0 next cycle.
- eret lane: ws_flush=ws_eret=1; younger lanes squashed; ws_valid=0 next cycle.
- ready_go: high when the group contains the last occupied lane, or ws_flush, or mask is exhausted.
  - Otherwise cur advances past the group's last lane and the stage holds.
- ws_allowin = !ws_valid || ready_go.
- Flush priority: in a flush cycle the offered bundle is dropped even though ws_allowin=1; MEM is flushed by ws_flush in the same cycle.
- Latency: a bundle with n occupied lanes and c CP0 lanes retires in max(ceil(n/RF_WPORTS), c) or more cycles; with no CP0 lanes, back-to-back acceptance has no bubbles.

Decomposition:
- Shared header (mycpu.h) holds:
  - `WS_LANE_WD (149).
  - Field offset macros.
  - `WB_TO_CP0_REGISTER_BUS_WD.
  - Excode constants (INT 0x00, ADEL 0x04, ADES 0x05, SYS 0x08, BP 0x09, RI 0x0a, OV 0x0c).
- One sub-module, wb_group_sel: combinational. Inputs mask, cur, per-lane CP0 flags. Outputs per-port lane index and valid, next cur, last_group.

Test Plan:
- LANES=2, RF_WPORTS=1, mask=2'b11, lane0 {dest=3, result=0x11}, lane1 {dest=4, result=0x22} -> cycle1 rf_we=1 waddr=3 wdata=0x11 with ws_allowin=0; cycle2 waddr=4 wdata=0x22 with ws_allowin=1.
- lane0 ex=1, excode=0x04, badvaddr=0x8000_0003, lane1 gr_we=1 -> cp0 bus ex=1 excode=0x04 badvaddr=0x8000_0003, ws_flush=1, rf_we=0, lane1 never written, ws_valid=0 next cycle.
- RF_WPORTS=2, lane0 ALU dest=5, lane1 mfc0 dest=6 cp0_addr=12, cp0_rdata=0x0040_FF01 -> same cycle: port0 waddr=5, port1 waddr=6 wdata=0x0040_FF01, ws_cp0_raddr=12.
- mask=2'b10, lane1 pc=0xBFC0_0104 -> one cycle; debug_wb_pc[port0]=0xBFC0_0104; no lane0 effect.
- resetn=0 while cur=1 of a two-cycle bundle -> next cycle ws_valid=0, rf_we=0, ws_allowin=1; lane1 never retired.
- RF_WPORTS=2, five consecutive full ALU bundles -> one bundle retired per cycle, ws_allowin constantly 1, trace PCs in order.

Source files
------------

// File: rtl/wb_commit_stage_pkg.sv
// wb_commit_stage_pkg: lane layout, CP0 bus width and excode constants shared by the WB stage
package wb_commit_stage_pkg;

    localparam int WS_LANE_WD = 149;
    localparam int WB_TO_CP0_REGISTER_BUS_WD = 110;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    typedef struct packed {
        logic [31:0] rt_value;
        logic        eret;
        logic        bd;
        logic        mtc0;
        logic [4:0]  cp0_addr;
        logic        res_from_cp0;
        logic [31:0] badvaddr;
        logic        ex;
        logic [4:0]  excode;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } ws_lane_t;

    function automatic logic is_cp0_lane(input ws_lane_t l);
        return l.ex | l.eret | l.mtc0 | l.res_from_cp0;
    endfunction

endpackage

// File: rtl/wb_commit_stage_if.sv
// wb_commit_stage_if: MEM->WB bundle handshake
interface wb_commit_stage_if import wb_commit_stage_pkg::*; #(
    parameter int LANES = 2
);
    logic                        ws_allowin;
    logic                        ms_to_ws_valid;
    logic [LANES-1:0]            ms_to_ws_lane_mask;
    logic [LANES*WS_LANE_WD-1:0] ms_to_ws_bus;

    modport master (output ms_to_ws_valid, ms_to_ws_lane_mask, ms_to_ws_bus, input ws_allowin);
    modport slave  (input ms_to_ws_valid, ms_to_ws_lane_mask, ms_to_ws_bus, output ws_allowin);
endinterface

// File: rtl/wb_group_sel.sv
// wb_group_sel: picks the lanes retired this cycle, ending the group at the first CP0 lane
module wb_group_sel #(
    parameter int LANES = 2,
    parameter int RF_WPORTS = 1,
    localparam int CW = $clog2(LANES) + 1,
    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [LANES-1:0]               mask,
    input  logic [CW-1:0]                  cur,
    input  logic [LANES-1:0]               cp0_lane,
    output logic [RF_WPORTS-1:0][IW-1:0]   port_idx,
    output logic [RF_WPORTS-1:0]           port_vld,
    output logic [CW-1:0]                  next_cur,
    output logic                           last_group
);

    // walk lanes from cur, packing occupied ones onto ports in order
    always_comb begin
        int cnt;
        logic stop;
        logic take;
        port_idx = '0;
        port_vld = '0;
        next_cur = cur;
        last_group = 1'b1;
        cnt = 0;
        stop = 1'b0;
        take = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            take = !stop && cnt < RF_WPORTS && i >= int'(cur) && mask[i];
            for (int p = 0; p < RF_WPORTS; p++) begin
                if (take && cnt == p) begin
                    port_idx[p] = IW'(i);
                    port_vld[p] = 1'b1;
                end
            end
            if (take) begin
                cnt = cnt + 1;
                next_cur = CW'(i + 1);
                stop = cp0_lane[i];
            end
        end
        for (int i = 0; i < LANES; i++)
            if (i >= int'(next_cur) && mask[i]) last_group = 1'b0;
    end

endmodule

// File: rtl/wb_commit_stage.sv
// wb_commit_stage: retires MEM bundles in order through the RF write ports and drives CP0
module wb_commit_stage import wb_commit_stage_pkg::*; #(
    parameter int LANES = 2,
    parameter int RF_WPORTS = 1,
    parameter int DATA_W = 32
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    wb_commit_stage_if.slave                      ms,
    output logic [4:0]                            ws_cp0_raddr,
    input  logic [DATA_W-1:0]                     cp0_rdata,
    output logic [WB_TO_CP0_REGISTER_BUS_WD-1:0]  wb_to_cp0_register_bus,
    output logic                                  ws_flush,
    output logic                                  ws_eret,
    output logic [RF_WPORTS-1:0]                  rf_we,
    output logic [RF_WPORTS*5-1:0]                rf_waddr,
    output logic [RF_WPORTS*DATA_W-1:0]           rf_wdata,
    output logic [RF_WPORTS*32-1:0]               debug_wb_pc,
    output logic [RF_WPORTS*4-1:0]                debug_wb_rf_wen,
    output logic [RF_WPORTS*5-1:0]                debug_wb_rf_wnum,
    output logic [RF_WPORTS*DATA_W-1:0]           debug_wb_rf_wdata
);

    localparam int CW = $clog2(LANES) + 1;
    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

    logic                        ws_valid;
    logic [LANES*WS_LANE_WD-1:0] bus_r;
    logic [LANES-1:0]            mask_r;
    logic [CW-1:0]               cur;
    ws_lane_t                    lane [LANES];
    logic [LANES-1:0]            cp0_lane;
    logic [RF_WPORTS-1:0][IW-1:0] port_idx;
    logic [RF_WPORTS-1:0]        port_vld;
    logic [CW-1:0]               next_cur;
    logic                        last_group;
    logic                        has_cp0;
    ws_lane_t                    cp0_l;
    ws_lane_t                    sel;
    logic                        ready_go;
    logic                        allowin;
    logic                        accept;

    // unpack the held bundle and flag lanes that touch CP0
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane[i] = bus_r[i*WS_LANE_WD +: WS_LANE_WD];
            cp0_lane[i] = is_cp0_lane(lane[i]);
        end
    end

    wb_group_sel #(.LANES(LANES), .RF_WPORTS(RF_WPORTS)) u_sel (
        .mask(mask_r),
        .cur(cur),
        .cp0_lane(cp0_lane),
        .port_idx(port_idx),
        .port_vld(port_vld),
        .next_cur(next_cur),
        .last_group(last_group)
    );

    // the group holds at most one CP0 lane, always its last one
    always_comb begin
        has_cp0 = 1'b0;
        cp0_l = '0;
        for (int p = 0; p < RF_WPORTS; p++) begin
            if (ws_valid && port_vld[p] && cp0_lane[port_idx[p]]) begin
                has_cp0 = 1'b1;
                cp0_l = lane[port_idx[p]];
            end
        end
    end

    // port p carries the p-th lane of the group; excepting lanes never write the RF
    always_comb begin
        rf_we = '0;
        rf_waddr = '0;
        rf_wdata = '0;
        debug_wb_pc = '0;
        sel = '0;
        for (int p = 0; p < RF_WPORTS; p++) begin
            if (ws_valid && port_vld[p]) begin
                sel = lane[port_idx[p]];
                rf_we[p] = sel.gr_we && !sel.ex;
                rf_waddr[p*5 +: 5] = sel.dest;
                rf_wdata[p*DATA_W +: DATA_W] = sel.res_from_cp0 ? cp0_rdata : DATA_W'(sel.result);
                debug_wb_pc[p*32 +: 32] = sel.pc;
            end
        end
    end

    assign ws_cp0_raddr = has_cp0 ? cp0_l.cp0_addr : 5'd0;
    assign wb_to_cp0_register_bus = has_cp0 ? {cp0_l.ex, cp0_l.excode, cp0_l.badvaddr, cp0_l.bd, cp0_l.pc,
                                               cp0_l.mtc0 && ws_valid, cp0_l.cp0_addr, cp0_l.rt_value, cp0_l.eret}
                                            : '0;
    assign ws_flush = has_cp0 && (cp0_l.ex || cp0_l.eret);
    assign ws_eret  = has_cp0 && cp0_l.eret && !cp0_l.ex;
    assign ready_go = last_group || ws_flush;
    assign allowin  = !ws_valid || ready_go;
    assign accept   = ms.ms_to_ws_valid && allowin && !ws_flush;
    assign ms.ws_allowin = allowin;

    genvar p;
    for (p = 0; p < RF_WPORTS; p++) begin : g_trace
        assign debug_wb_rf_wen[p*4 +: 4] = {4{rf_we[p]}};
    end
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

    // stage occupancy and retire pointer; a flush or the last group empties the stage
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ws_valid <= 1'b0;
            mask_r <= '0;
            cur <= '0;
        end else if (accept) begin
            ws_valid <= 1'b1;
            mask_r <= ms.ms_to_ws_lane_mask;
            cur <= '0;
        end else if (ws_valid && ready_go) begin
            ws_valid <= 1'b0;
        end else if (ws_valid) begin
            cur <= next_cur;
        end
    end

    // bundle payload only needs capturing on acceptance
    always_ff @(posedge clk) begin
        if (resetn && accept) bus_r <= ms.ms_to_ws_bus;
    end

endmodule
